// File: rtl/stream_mux_nto1.sv
// N-to-1 valid/ready stream multiplexer with registered output; fixed-select or round-robin grant.
// Define STREAM_MUX_LAST_LOCK_EN to add in_last/out_last and hold the grant until a packet's last beat.
module stream_mux_nto1 #(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEL_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      s,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
`ifdef STREAM_MUX_LAST_LOCK_EN
  input  logic [N_CH-1:0]       in_last,
  output logic                  out_last,
`endif
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  input  logic                  out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             take;
  logic             accept;
  logic             fx_vld, rr_vld, gnt_vld;
  logic [SEL_W-1:0] rr_ch, gnt_ch;
  logic             beat_last;
  int unsigned      idx;

`ifdef STREAM_MUX_LAST_LOCK_EN
  typedef enum logic {UNLOCKED, LOCKED} lock_e;
  lock_e            lock_q, lock_d;
  logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
  logic             out_last_q, out_last_d;
`endif

  assign take = !out_valid_q || out_ready;

  // Fixed select: selects beyond the channel count grant nothing.
  always_comb begin
    fx_vld = 1'b0;
    if (32'(s) < N_CH) fx_vld = in_valid[s];
  end

  // Round-robin: first valid channel at or above ptr, wrapping modulo N_CH.
  always_comb begin
    rr_vld = 1'b0;
    rr_ch  = '0;
    idx    = 0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!rr_vld && in_valid[idx]) begin
        rr_vld = 1'b1;
        rr_ch  = SEL_W'(idx);
      end
    end
  end

  always_comb begin
    gnt_vld = mode ? rr_vld : fx_vld;
    gnt_ch  = mode ? rr_ch  : s;
`ifdef STREAM_MUX_LAST_LOCK_EN
    if (lock_q == LOCKED) begin
      gnt_vld = in_valid[lock_ch_q];
      gnt_ch  = lock_ch_q;
    end
`endif
  end

  assign accept = take && gnt_vld;

`ifdef STREAM_MUX_LAST_LOCK_EN
  assign beat_last = in_last[gnt_ch];
`else
  assign beat_last = 1'b1;
`endif

  always_comb begin
    in_ready = '0;
    if (rst_n && accept) in_ready[gnt_ch] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (take) out_valid_d = gnt_vld;
    if (accept) begin
      out_data_d = in_data[32'(gnt_ch)*WIDTH +: WIDTH];
      out_ch_d   = gnt_ch;
      // Pointer moves only on packet boundaries so a locked packet does not skew fairness.
      if (mode && beat_last) begin
        if (32'(gnt_ch) == N_CH - 1) ptr_d = '0;
        else                         ptr_d = gnt_ch + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

`ifdef STREAM_MUX_LAST_LOCK_EN
  always_comb begin
    lock_d     = lock_q;
    lock_ch_d  = lock_ch_q;
    out_last_d = out_last_q;
    if (accept) begin
      out_last_d = beat_last;
      if (beat_last) begin
        lock_d = UNLOCKED;
      end else begin
        lock_d    = LOCKED;
        lock_ch_d = gnt_ch;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q     <= UNLOCKED;
      lock_ch_q  <= '0;
      out_last_q <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_ch_q  <= lock_ch_d;
      out_last_q <= out_last_d;
    end
  end

  assign out_last = out_last_q;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule
